song_reader: RTL and testbench
==============================

SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter NOTE_BITS, default 6: width of the note code.
REQ-002 Parameter DUR_BITS, default 6: width of the note duration in beats.
REQ-003 Parameter INDEX_BITS, default 5: note-index width, giving 32 notes per song.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port play, input, 1: 1 = run, 0 = pause (new fetches suppressed).
REQ-007 Port reset_play, input, 1: synchronous restart of the current song from note 0.
REQ-008 Port song, input, 2: selected song number.
REQ-009 Port note_done, input, 1: one-cycle pulse from the note player when the current note's duration has elapsed.
REQ-010 Port note, output, NOTE_BITS: registered note code of the current note.
REQ-011 Port duration, output, DUR_BITS: registered duration of the current note.
REQ-012 Port new_note, output, 1: one-cycle pulse when note and duration are updated.
REQ-013 Port song_done, output, 1: one-cycle pulse at end of song.

Function
REQ-014 The ROM address shall be {song, index}, 7 bits by default; the ROM word shall be {note, duration}, 12 bits by default.
REQ-015 The ROM read shall be synchronous, with 1-cycle latency.
REQ-016 The FSM shall have the states IDLE, FETCH, WAIT_ROM, WAIT_NOTE and DONE.
REQ-017 IDLE -> FETCH when play=1; otherwise the FSM stays in IDLE.
REQ-018 FETCH shall present the address {song, index} to the ROM, then go unconditionally to WAIT_ROM.
REQ-019 In WAIT_ROM, when the ROM duration is non-zero: register note and duration, pulse new_note, then go to WAIT_NOTE.
REQ-020 In WAIT_ROM, when the ROM duration is 0 (end marker): go to DONE with no new_note and with note and duration unchanged.
REQ-021 Latency: if play is sampled 1 in IDLE at edge E0, new_note shall be high in the cycle after edge E0+2.
REQ-022 In WAIT_NOTE, note_done=1 shall cause the following:
- if index = 2^INDEX_BITS-1: go to DONE;
- otherwise: increment index and go to IDLE.
REQ-023 In WAIT_NOTE, note_done is accepted regardless of play; the pause takes effect at the next IDLE.
REQ-024 note_done shall be ignored in every state other than WAIT_NOTE.
REQ-025 Entry into DONE shall pulse song_done for exactly one cycle.
REQ-026 The FSM shall stay in DONE until reset_play or reset.
REQ-027 reset_play=1 shall set index to 0 and the state to IDLE, and clear new_note and song_done.
REQ-028 reset_play shall leave note and duration unchanged.
REQ-029 reset_play shall take priority over note_done, play and all FSM transitions.
REQ-030 The song input shall be sampled only in FETCH; a song change takes effect at the next fetch, and song changes are normally accompanied by reset_play.
REQ-031 The index shall never wrap silently; the last index always ends the song via DONE.
REQ-032 new_note and song_done shall never be high in the same cycle.

Reset
REQ-033 reset=1 shall asynchronously force state = IDLE, index = 0, note = 0, duration = 0, new_note = 0, song_done = 0.
REQ-034 After reset deasserts, the first fetch shall occur only when play=1.

Structure
REQ-035 State encodings, the ROM word layout and the default widths shall live in the shared song definitions package/include used by the music-player blocks.
REQ-036 The ROM shall be a separate sub-module song_rom (address in, registered data out), instantiated once in song_reader.
REQ-037 The index shall be held locally in song_reader, not in a generic counter, because of the terminal-index and clear rules.

Verification
REQ-038 Reset then play=1, song=0, with ROM[0] = {note 5, duration 4}: new_note is high 2 edges after play is sampled, with note=5 and duration=4.
REQ-039 Pause: play=0 during WAIT_NOTE, then note_done: the FSM goes to IDLE and no new_note occurs until play=1.
REQ-040 End marker: song 1 with ROM[{1,3}].duration=0: after the 3rd note_done, song_done pulses once and new_note stays 0.
REQ-041 Full song: song 2 with all 32 words non-zero: 32 new_note pulses, then song_done after the 32nd note_done, and the FSM stays in DONE.
REQ-042 reset_play asserted in the same cycle as note_done while at index 7: index becomes 0, the state becomes IDLE and no song_done is produced.
REQ-043 Asynchronous reset asserted mid-WAIT_ROM: all outputs are 0 immediately (before the next edge), with no new_note.

Source files
------------

// File: rtl/song_reader_pkg.sv
// Shared song definitions: default field widths, song-select width and the
// reader FSM state encoding used by the music-player blocks.
package song_reader_pkg;

    localparam int NOTE_BITS_DEF  = 6;
    localparam int DUR_BITS_DEF   = 6;
    localparam int INDEX_BITS_DEF = 5;
    localparam int SONG_BITS      = 2;

    // ROM word layout: {note, duration}; a duration of 0 marks the end of a song.
    localparam int DUR_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_ROM  = 3'd2,
        S_WAIT_NOTE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/song_rom.sv
// Song ROM with a registered read port: the data for addr appears one cycle later.
module song_rom
    import song_reader_pkg::*;
#(
    parameter int NOTE_BITS  = NOTE_BITS_DEF,
    parameter int DUR_BITS   = DUR_BITS_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    localparam int ADDR_BITS = SONG_BITS + INDEX_BITS,
    localparam int WORD_BITS = NOTE_BITS + DUR_BITS
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [WORD_BITS-1:0] data
);

    // Song 0 ends at index 12, song 1 at index 3, song 2 uses all slots,
    // song 3 ends at index 15.
    function automatic logic [WORD_BITS-1:0] rom_word(input logic [ADDR_BITS-1:0] a);
        int s;
        int i;
        int n;
        int d;
        s = int'(a[ADDR_BITS-1:INDEX_BITS]);
        i = int'(a[INDEX_BITS-1:0]);
        case (s)
            0: begin
                n = 5 + i;
                d = (i >= 12) ? 0 : 4 + (i % 3);
            end
            1: begin
                n = 20 + i;
                d = (i == 3) ? 0 : i + 1;
            end
            2: begin
                n = 40 + (i % 16);
                d = 1 + (i % 8);
            end
            default: begin
                n = 63 - i;
                d = (i == 15) ? 0 : 2;
            end
        endcase
        return {NOTE_BITS'(n), DUR_BITS'(d)};
    endfunction

    always_ff @(posedge clk) begin
        data <= rom_word(addr);
    end

endmodule

// File: rtl/song_reader.sv
// Walks the selected song in ROM one note at a time, handing each note to the
// note player and signalling the end of the song.
module song_reader
    import song_reader_pkg::*;
#(
    parameter int NOTE_BITS  = NOTE_BITS_DEF,
    parameter int DUR_BITS   = DUR_BITS_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play,
    input  logic                 reset_play,
    input  logic [SONG_BITS-1:0] song,
    input  logic                 note_done,
    output logic [NOTE_BITS-1:0] note,
    output logic [DUR_BITS-1:0]  duration,
    output logic                 new_note,
    output logic                 song_done,
    output state_t               state_dbg
);

    // Handshake with the note player: new_note is a one-cycle pulse that
    // announces a fresh {note, duration}; note_done is a one-cycle pulse back,
    // honoured only while waiting on the current note (no valid/ready stall).

    state_t state, state_next;
    logic [INDEX_BITS-1:0]          index_q;
    logic [NOTE_BITS+DUR_BITS-1:0]  rom_data;
    logic [NOTE_BITS-1:0]           rom_note;
    logic [DUR_BITS-1:0]            rom_dur;
    logic                           load_note;
    logic                           enter_done;
    logic                           index_inc;

    song_rom #(
        .NOTE_BITS  (NOTE_BITS),
        .DUR_BITS   (DUR_BITS),
        .INDEX_BITS (INDEX_BITS)
    ) u_rom (
        .clk  (clk),
        .addr ({song, index_q}),
        .data (rom_data)
    );

    assign rom_note  = rom_data[NOTE_BITS+DUR_BITS-1:DUR_BITS];
    assign rom_dur   = rom_data[DUR_LSB +: DUR_BITS];
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        load_note  = 1'b0;
        enter_done = 1'b0;
        index_inc  = 1'b0;
        case (state)
            S_IDLE:      if (play) state_next = S_FETCH;
            S_FETCH:     state_next = S_WAIT_ROM;
            S_WAIT_ROM: begin
                if (rom_dur != '0) begin
                    load_note  = 1'b1;
                    state_next = S_WAIT_NOTE;
                end else begin
                    enter_done = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_WAIT_NOTE: begin
                if (note_done) begin
                    if (index_q == '1) begin
                        enter_done = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        index_inc  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_DONE:      state_next = S_DONE;
            default:     state_next = S_IDLE;
        endcase
        // Restart overrides everything, including a note_done in the same cycle.
        if (reset_play) begin
            state_next = S_IDLE;
            load_note  = 1'b0;
            enter_done = 1'b0;
            index_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            index_q   <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_next;
            new_note  <= load_note;
            song_done <= enter_done;
            if (reset_play)
                index_q <= '0;
            else if (index_inc)
                index_q <= index_q + INDEX_BITS'(1);
            if (load_note) begin
                note     <= rom_note;
                duration <= rom_dur;
            end
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: directed scenarios plus randomized song playback
// checked against a song-level model of the ROM contents.
module tb_song_reader;
    import song_reader_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic       reset_play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;
    state_t     state_dbg;

    int checks = 0;
    int errors = 0;

    song_reader dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .reset_play (reset_play),
        .song       (song),
        .note_done  (note_done),
        .note       (note),
        .duration   (duration),
        .new_note   (new_note),
        .song_done  (song_done),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Expected song content as {note, duration}; duration 0 ends the song.
    function automatic logic [11:0] model_word(input int s, input int i);
        int n;
        int d;
        if (s == 0) begin
            n = 5 + i;
            d = (i < 12) ? 4 + (i % 3) : 0;
        end else if (s == 1) begin
            n = 20 + i;
            d = (i == 3) ? 0 : i + 1;
        end else if (s == 2) begin
            n = 40 + (i % 16);
            d = 1 + (i % 8);
        end else begin
            n = 63 - i;
            d = (i == 15) ? 0 : 2;
        end
        return {n[5:0], d[5:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_note_done();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
    endtask

    // Waits for new_note and checks it carries the expected word.
    task automatic expect_note(input string name, input logic [11:0] exp);
        int n = 0;
        while (!new_note && !song_done && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!new_note || song_done || {note, duration} !== exp) begin
            errors++;
            $display("FAIL %s: new_note=%0b song_done=%0b word=%03h expected word=%03h",
                     name, new_note, song_done, {note, duration}, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b0; reset_play = 1'b0; song = 2'd0; note_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({note, duration, new_note, song_done} !== 14'd0 || state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: outputs=%04h state=%0d expected 0000 state=%0d",
                     {note, duration, new_note, song_done}, state_dbg, S_IDLE);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (new_note !== 1'b0 || state_dbg !== S_IDLE) begin
                errors++;
                $display("FAIL idle_without_play: new_note=%0b state=%0d expected 0 and IDLE",
                         new_note, state_dbg);
            end
        end
    endtask

    // play sampled at edge E0; new_note must be visible just after E0+2.
    task automatic test_latency();
        play = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (new_note !== (e == 2)) begin
                errors++;
                $display("FAIL latency_edge%0d: new_note=%0b expected %0b", e, new_note, e == 2);
            end
        end
        checks++;
        if (note !== 6'd5 || duration !== 6'd4) begin
            errors++;
            $display("FAIL first_note: note=%0d duration=%0d expected 5 and 4", note, duration);
        end
    endtask

    task automatic test_pause();
        int k;
        play = 1'b0;
        pulse_note_done();
        k = $urandom_range(4, 10);
        for (int i = 0; i < k; i++) begin
            checks++;
            if (new_note !== 1'b0 || state_dbg !== S_IDLE) begin
                errors++;
                $display("FAIL pause_hold: new_note=%0b state=%0d expected 0 and IDLE",
                         new_note, state_dbg);
            end
            tick();
        end
        play = 1'b1;
        expect_note("pause_resume", model_word(0, 1));
    endtask

    task automatic test_restart_at_index7();
        for (int i = 2; i <= 7; i++) begin
            tick();
            pulse_note_done();
            expect_note("walk_to_7", model_word(0, i));
        end
        reset_play = 1'b1;
        note_done  = 1'b1;
        tick();
        reset_play = 1'b0;
        note_done  = 1'b0;
        checks++;
        if (state_dbg !== S_IDLE || song_done !== 1'b0 || new_note !== 1'b0
            || {note, duration} !== model_word(0, 7)) begin
            errors++;
            $display("FAIL restart_priority: state=%0d song_done=%0b new_note=%0b word=%03h expected IDLE 0 0 %03h",
                     state_dbg, song_done, new_note, {note, duration}, model_word(0, 7));
        end
        expect_note("restart_from_0", model_word(0, 0));
    endtask

    task automatic test_async_reset();
        pulse_note_done();
        tick();
        tick();
        checks++;
        if (state_dbg !== S_WAIT_ROM) begin
            errors++;
            $display("FAIL reach_wait_rom: state=%0d expected %0d", state_dbg, S_WAIT_ROM);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({note, duration, new_note, song_done} !== 14'd0 || state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL async_reset: outputs=%04h state=%0d expected 0000 and IDLE",
                     {note, duration, new_note, song_done}, state_dbg);
        end
        play = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (new_note !== 1'b0 || song_done !== 1'b0) begin
                errors++;
                $display("FAIL after_reset_quiet: new_note=%0b song_done=%0b expected 0 0",
                         new_note, song_done);
            end
        end
    endtask

    // Plays a whole song from a restart with random note gaps and pauses.
    task automatic run_song(input int s, output int pulses);
        logic [11:0] exp_q[$];
        logic [11:0] exp_w;
        int n;
        int k;
        bit fin;
        bit paused;
        for (int i = 0; i < 32; i++) begin
            exp_w = model_word(s, i);
            if (exp_w[5:0] == 6'd0) break;
            exp_q.push_back(exp_w);
        end
        song = s[1:0];
        play = 1'b1;
        reset_play = 1'b1;
        tick();
        reset_play = 1'b0;
        pulses = 0;
        fin = 1'b0;
        while (!fin) begin
            n = 0;
            while (!new_note && !song_done && n < 200) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 200 || (new_note && song_done)) begin
                errors++;
                $display("FAIL song%0d_event: new_note=%0b song_done=%0b after %0d cycles",
                         s, new_note, song_done, n);
                fin = 1'b1;
            end else if (new_note) begin
                pulses++;
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
                if ({note, duration} !== exp_w) begin
                    errors++;
                    $display("FAIL song%0d_note%0d: word=%03h expected %03h",
                             s, pulses - 1, {note, duration}, exp_w);
                end
                k = $urandom_range(0, 3);
                for (int g = 0; g < k; g++) tick();
                paused = (pulses < 32) && ($urandom_range(0, 3) == 0);
                if (paused) play = 1'b0;
                tick();
                pulse_note_done();
                if (paused) begin
                    k = $urandom_range(2, 6);
                    for (int g = 0; g < k; g++) begin
                        checks++;
                        if (new_note !== 1'b0 || state_dbg !== S_IDLE) begin
                            errors++;
                            $display("FAIL song%0d_pause: new_note=%0b state=%0d expected 0 and IDLE",
                                     s, new_note, state_dbg);
                        end
                        tick();
                    end
                    play = 1'b1;
                end
            end else begin
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL song%0d_early_done: %0d notes still expected", s, exp_q.size());
                end
                fin = 1'b1;
            end
        end
        tick();
        checks++;
        if (song_done !== 1'b0 || new_note !== 1'b0 || state_dbg !== S_DONE) begin
            errors++;
            $display("FAIL song%0d_done_hold: song_done=%0b new_note=%0b state=%0d expected 0 0 DONE",
                     s, song_done, new_note, state_dbg);
        end
        pulse_note_done();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (new_note !== 1'b0 || song_done !== 1'b0 || state_dbg !== S_DONE) begin
                errors++;
                $display("FAIL song%0d_stay_done: new_note=%0b song_done=%0b state=%0d expected 0 0 DONE",
                         s, new_note, song_done, state_dbg);
            end
        end
    endtask

    task automatic test_end_marker();
        int pulses;
        run_song(1, pulses);
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL end_marker_count: new_note pulses=%0d expected 3", pulses);
        end
    endtask

    task automatic test_full_song();
        int pulses;
        run_song(2, pulses);
        checks++;
        if (pulses !== 32) begin
            errors++;
            $display("FAIL full_song_count: new_note pulses=%0d expected 32", pulses);
        end
    endtask

    task automatic test_random_songs();
        int pulses;
        int s;
        for (int r = 0; r < 6; r++) begin
            s = $urandom_range(0, 3);
            run_song(s, pulses);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pause();
        test_restart_at_index7();
        test_async_reset();
        test_end_marker();
        test_full_song();
        test_random_songs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
